// File: rtl/vga_pixel_writer.sv
// Pixel FIFO and framebuffer write port with hardware full-screen fill.
// Optional: VGA_PW_TRANSPARENT_EN drops pixels of TRANSPARENT_COLOR.
module vga_pixel_writer #(
    parameter int         DEPTH             = 16,
    parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  color,
    input  logic        fill_start,
    input  logic [2:0]  fill_color,
    input  logic        mem_ready,
    output logic        mem_wren,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        busy,
    output logic        fill_done,
    output logic        overflow
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [16:0] LAST_ADDR = 17'd76799;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL,
        FILL_DONE
    } state_t;

    state_t state, state_n;

    logic [19:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic [AW-1:0] nxt_idx;
    logic          empty, full, one_left;
    logic          in_range, keep, push_req, push, pop;
    logic [16:0]   pix_addr;
    logic [19:0]   head, nxt_head;
    logic          fill_pending;
    logic [2:0]    fill_color_q;
    logic          accept;
    logic          ld_head, ld_next, ld_fill, inc_fill, clr_wren, clr_pending;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign one_left = (count == (AW+1)'(1));
    assign nxt_idx  = rd_ptr[AW-1:0] + AW'(1);
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign nxt_head = fifo_mem[nxt_idx];
    assign accept   = mem_wren && mem_ready;

    assign in_range = plot && (x < 9'd320) && (y < 8'd240);
`ifdef VGA_PW_TRANSPARENT_EN
    assign keep = (color != TRANSPARENT_COLOR);
`else
    logic unused_tc;
    assign unused_tc = ^TRANSPARENT_COLOR;
    assign keep      = 1'b1;
`endif
    assign push_req = in_range && keep;
    assign push     = push_req && !full;

    // y*320 + x as y*256 + y*64 + x
    assign pix_addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};

    assign busy = (state != IDLE) || !empty || fill_pending || mem_wren;

    // FIFO pointers; the head stays queued until its write is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage holds precomputed address and color
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {pix_addr, color};
    end

    // Sticky drop flag; full is judged before any same-cycle pop
    always_ff @(posedge clock) begin
        if (reset)                 overflow <= 1'b0;
        else if (push_req && full) overflow <= 1'b1;
    end

    // Fill request latch, ignored while a fill is pending or running
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_pending <= 1'b0;
            fill_color_q <= 3'b000;
        end else if (clr_pending) begin
            fill_pending <= 1'b0;
        end else if (fill_start && state != FILL && !fill_pending) begin
            fill_pending <= 1'b1;
            fill_color_q <= fill_color;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and datapath control
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        ld_head     = 1'b0;
        ld_next     = 1'b0;
        ld_fill     = 1'b0;
        inc_fill    = 1'b0;
        clr_wren    = 1'b0;
        clr_pending = 1'b0;
        fill_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fill_pending && empty && !mem_wren) begin
                    state_n = FILL;
                    ld_fill = 1'b1;
                end else if (!empty) begin
                    state_n = DRAIN;
                    ld_head = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    pop = 1'b1;
                    if (one_left) begin
                        clr_wren = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        ld_next = 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (mem_addr == LAST_ADDR) begin
                        clr_wren = 1'b1;
                        state_n  = FILL_DONE;
                    end else begin
                        inc_fill = 1'b1;
                    end
                end
            end
            FILL_DONE: begin
                fill_done   = 1'b1;
                clr_pending = 1'b1;
                if (!empty) begin
                    state_n = DRAIN;
                    ld_head = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered write port; untouched while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (ld_fill) begin
            mem_wren <= 1'b1;
            mem_addr <= '0;
            mem_data <= fill_color_q;
        end else if (ld_head) begin
            mem_wren <= 1'b1;
            {mem_addr, mem_data} <= head;
        end else if (ld_next) begin
            mem_wren <= 1'b1;
            {mem_addr, mem_data} <= nxt_head;
        end else if (inc_fill) begin
            mem_addr <= mem_addr + 17'd1;
        end else if (clr_wren) begin
            mem_wren <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Scoreboard bench for vga_pixel_writer: stimulus queues expected writes,
// a negedge monitor checks every accepted write and stall stability.
module tb_vga_pixel_writer;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        plot = 1'b0;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic [2:0]  color = '0;
    logic        fill_start = 1'b0;
    logic [2:0]  fill_color = '0;
    logic        mem_ready = 1'b1;
    logic        mem_wren;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        busy;
    logic        fill_done;
    logic        overflow;

    vga_pixel_writer #(.DEPTH(DEPTH), .TRANSPARENT_COLOR(3'b000)) dut (
        .clock      (clock),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .color      (color),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .mem_ready  (mem_ready),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .fill_done  (fill_done),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [16:0] prev_addr;
    logic [2:0]  prev_data;
    int          fd_cnt = 0;
    int          fd_qsize = -1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference rules: linear 320-wide address, range and color filter
    function automatic logic [19:0] ref_word(int xx, int yy, int c);
        int a;
        a = yy * 320 + xx;
        return {17'(a), 3'(c)};
    endfunction

    function automatic bit model_keeps(int xx, int yy, int c);
        bit k;
        k = (xx >= 0) && (xx < 320) && (yy >= 0) && (yy < 240);
`ifdef VGA_PW_TRANSPARENT_EN
        if (c == 0) k = 1'b0;
`endif
        return k;
    endfunction

    task automatic drive_px(int xx, int yy, int c, bit expect_it);
        plot  = 1'b1;
        x     = 9'(xx);
        y     = 8'(yy);
        color = 3'(c);
        if (expect_it) exp_q.push_back(ref_word(xx, yy, c));
        tick();
        plot = 1'b0;
    endtask

    task automatic plot_px(int xx, int yy, int c);
        drive_px(xx, yy, c, model_keeps(xx, yy, c));
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        reset      = 1'b1;
        plot       = 1'b0;
        fill_start = 1'b0;
        mem_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        mon_en = 1'b1;
    endtask

    task automatic wait_idle(string nm, int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_idle_timeout"}, 32'(n < budget), 32'd1);
    endtask

    // Monitor: pops one expectation per accepted write
    always @(negedge clock) begin
        logic [19:0] e;
        if (mon_en) begin
            if (stall_prev) begin
                n_vec++;
                if (!mem_wren || mem_addr !== prev_addr ||
                    mem_data !== prev_data) begin
                    n_err++;
                    $display("FAIL hold: got wren=%0d addr=%0d data=%0d, expected 1/%0d/%0d",
                             mem_wren, mem_addr, mem_data, prev_addr, prev_data);
                end
            end
            if (mem_wren && mem_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write: got unexpected addr=%0d data=%0d, expected none",
                             mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_data} !== e) begin
                        n_err++;
                        $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                                 mem_addr, mem_data, e[19:3], e[2:0]);
                    end
                end
            end
            if (fill_done) begin
                fd_cnt++;
                fd_qsize = exp_q.size();
            end
            stall_prev = mem_wren && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        do_reset();

        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Two-cycle latency into an idle writer
        drive_px(5, 2, 3, 1'b1);
        tick();
        check("lat_wren", 32'(mem_wren), 32'd1);
        check("lat_addr", 32'(mem_addr), 32'd645);
        check("lat_data", 32'(mem_data), 32'd3);
        tick();
        check("lat_wren_off", 32'(mem_wren), 32'd0);
        check("lat_busy_off", 32'(busy), 32'd0);

        // Corner pixel held under back-pressure
        mem_ready = 1'b0;
        drive_px(319, 239, 7, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_wren", 32'(mem_wren), 32'd1);
            check("stall_addr", 32'(mem_addr), 32'd76799);
            check("stall_data", 32'(mem_data), 32'd7);
            tick();
        end
        mem_ready = 1'b1;
        wait_idle("stall", 20);

        // Overfill: 17 pixels into a 16-entry FIFO with no draining
        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_px(i * 7, i * 3, (i % 7) + 1, i < DEPTH);
        end
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        mem_ready = 1'b1;
        wait_idle("ovf_drain", 100);
        check("ovf_sticky", 32'(overflow), 32'd1);

        do_reset();

        // Out-of-range pixels vanish without side effects
        plot_px(320, 0, 5);
        plot_px(0, 240, 5);
        for (int i = 0; i < 4; i++) begin
            check("oor_busy", 32'(busy), 32'd0);
            check("oor_overflow", 32'(overflow), 32'd0);
            tick();
        end

        // Color filter
        plot_px(10, 10, 0);
        plot_px(11, 10, 4);
        wait_idle("transp", 20);

        // Random pixels with random back-pressure, never past capacity
        for (int i = 0; i < 1500; i++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                plot_px($urandom_range(0, 330), $urandom_range(0, 250),
                        $urandom_range(0, 7));
            end else begin
                tick();
            end
        end
        mem_ready = 1'b1;
        wait_idle("rand", 200);
        check("rand_overflow", 32'(overflow), 32'd0);

        // Pixels, then fill, then a pixel buffered during the fill
        plot_px(3, 4, 1);
        plot_px(7, 8, 6);
        fill_color = 3'd2;
        fill_start = 1'b1;
        for (int a = 0; a < 76800; a++) exp_q.push_back({17'(a), 3'd2});
        tick();
        fill_start = 1'b0;
        repeat (10) tick();
        plot_px(100, 50, 5);
        wait_idle("fill", 80000);
        check("fill_done_pulses", 32'(fd_cnt), 32'd1);
        check("fill_done_left", 32'(fd_qsize), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
